// File: rtl/uart_rx_mmio_pkg.sv
// uart_rx_mmio_pkg
// Shared definitions for the memory-mapped UART receiver: register word
// addresses, STATUS/RXDATA bit positions and the receiver FSM state type.
package uart_rx_mmio_pkg;

  localparam logic [1:0] UART_RXDATA = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;

  // RXDATA fields
  localparam int RXDATA_VALID = 8;

  // STATUS fields
  localparam int ST_BUSY      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_FULL      = 2;
  localparam int ST_OVERRUN   = 3;
  localparam int ST_FRAME_ERR = 4;
  localparam int ST_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx_mmio_core.sv
// uart_rx_core
// Serial front end of the receiver: synchronizes rxd, detects the start
// edge, centre-samples an 8N1 frame and reports the result.
//   i_clk, i_rst        clock, async active-high reset
//   i_rxd               raw serial input (idle high)
//   o_byte_valid        one-cycle pulse, o_byte_data holds a good byte
//   o_byte_data[7:0]    last received byte, LSB first on the wire
//   o_frame_err_pulse   one-cycle pulse, stop bit was sampled low
//   o_busy              FSM is not idle
//
// state | meaning
// IDLE  | waiting for a falling edge on the synchronized line
// START | timing to the middle of the start bit, rejecting glitches
// DATA  | sampling 8 data bits, one per bit period
// STOP  | sampling the stop bit, then reporting byte or frame error
module uart_rx_core
  import uart_rx_mmio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rxd,
  output logic       o_byte_valid,
  output logic [7:0] o_byte_data,
  output logic       o_frame_err_pulse,
  output logic       o_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CYC = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID_CYC  = CW'(CLKS_PER_BIT / 2 - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic [1:0]      r_warm;
  logic            r_prev;
  rx_state_t       r_state;
  logic [CW-1:0]   r_cyc;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            r_byte_valid;
  logic            r_frame_err;
  logic            w_fall;

  // The synchronizer resets to 1, so its output only reflects the real
  // line from the second clock after reset. Until then r_prev is held at 0,
  // which means a line that is already low at reset release cannot look
  // like a falling edge; it must go high first.
  assign w_fall = r_prev & ~r_sync2;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1      <= 1'b1;
      r_sync2      <= 1'b1;
      r_warm       <= 2'b00;
      r_prev       <= 1'b0;
      r_state      <= IDLE;
      r_cyc        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_sync1      <= i_rxd;
      r_sync2      <= r_sync1;
      r_warm       <= {r_warm[0], 1'b1};
      r_prev       <= r_warm[1] & r_sync2;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_fall) begin
            r_state <= START;
            r_cyc   <= '0;
            r_bit   <= '0;
          end
        end
        START: begin
          if (r_cyc == MID_CYC) begin
            if (r_sync2) begin
              r_state <= IDLE;
            end else begin
              r_state <= DATA;
              r_cyc   <= '0;
            end
          end else begin
            r_cyc <= r_cyc + CW'(1);
          end
        end
        DATA: begin
          if (r_cyc == LAST_CYC) begin
            r_shift <= {r_sync2, r_shift[7:1]};
            r_cyc   <= '0;
            if (r_bit == 3'd7) begin
              r_state <= STOP;
            end else begin
              r_bit <= r_bit + 3'd1;
            end
          end else begin
            r_cyc <= r_cyc + CW'(1);
          end
        end
        STOP: begin
          if (r_cyc == LAST_CYC) begin
            if (r_sync2) begin
              r_byte_valid <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
            r_state <= IDLE;
          end else begin
            r_cyc <= r_cyc + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // r_shift only moves in DATA, so it is stable while o_byte_valid is high.
  assign o_byte_valid      = r_byte_valid;
  assign o_byte_data       = r_shift;
  assign o_frame_err_pulse = r_frame_err;
  assign o_busy            = (r_state != IDLE);

endmodule

// File: rtl/uart_rx_mmio.sv
// uart_rx_mmio
// Memory-mapped UART receiver: serial core, RX FIFO, sticky error flags
// and word-addressed register decode.
//   clk, rst            clock, async active-high reset
//   rxd                 serial input, idle high, asynchronous
//   bus_valid/write     one-cycle access strobe and direction
//   bus_addr[31:0]      byte address, [3:2] selects the register
//   bus_wdata[31:0]     write data (STATUS W1C bits 3 and 4)
//   mmio_rdata[31:0]    combinational read data
//   rx_irq_o            FIFO non-empty
//   fifo_count_o        FIFO occupancy 0..FIFO_DEPTH
//   rx_byte_fire_o      one-cycle pulse per byte written into the FIFO
module uart_rx_mmio
  import uart_rx_mmio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16,
  parameter int FIFO_AW      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rxd,
  input  logic               bus_valid,
  input  logic               bus_write,
  input  logic [31:0]        bus_addr,
  input  logic [31:0]        bus_wdata,
  output logic [31:0]        mmio_rdata,
  output logic               rx_irq_o,
  output logic [FIFO_AW:0]   fifo_count_o,
  output logic               rx_byte_fire_o
);

  logic               w_byte_valid;
  logic [7:0]         w_byte_data;
  logic               w_frame_err_pulse;
  logic               w_busy;

  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [FIFO_AW:0]   r_count;
  logic               r_overrun;
  logic               r_frame_err;

  logic [1:0]         w_addr_word;
  logic               w_empty;
  logic               w_full;
  logic               w_rd_rxdata;
  logic               w_wr_status;
  logic               w_pop;
  logic               w_push;
  logic               w_overrun_set;
  logic [31:0]        w_rdata;
  logic               w_unused_bits;

  uart_rx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_core (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_rxd             (rxd),
    .o_byte_valid      (w_byte_valid),
    .o_byte_data       (w_byte_data),
    .o_frame_err_pulse (w_frame_err_pulse),
    .o_busy            (w_busy)
  );

  assign w_addr_word = bus_addr[3:2];
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == (FIFO_AW + 1)'(FIFO_DEPTH));
  assign w_rd_rxdata = bus_valid & ~bus_write & (w_addr_word == UART_RXDATA);
  assign w_wr_status = bus_valid &  bus_write & (w_addr_word == UART_STATUS);
  assign w_pop       = w_rd_rxdata & ~w_empty;
  // A full FIFO still takes the byte when the same cycle frees a slot.
  assign w_push        = w_byte_valid & (~w_full | w_pop);
  assign w_overrun_set = w_byte_valid & w_full & ~w_pop;

  assign w_unused_bits = ^{bus_addr[31:4], bus_addr[1:0],
                           bus_wdata[31:5], bus_wdata[2:0]};

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_byte_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + FIFO_AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + FIFO_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (FIFO_AW + 1)'(1);
        2'b01:   r_count <= r_count - (FIFO_AW + 1)'(1);
        default: r_count <= r_count;
      endcase
      // Hardware set beats a simultaneous W1C clear.
      r_overrun   <= w_overrun_set |
                     (r_overrun & ~(w_wr_status & bus_wdata[ST_OVERRUN]));
      r_frame_err <= w_frame_err_pulse |
                     (r_frame_err & ~(w_wr_status & bus_wdata[ST_FRAME_ERR]));
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_addr_word)
      UART_RXDATA: begin
        if (!w_empty) begin
          w_rdata[7:0]         = r_mem[r_rptr];
          w_rdata[RXDATA_VALID] = 1'b1;
        end
      end
      UART_STATUS: begin
        w_rdata[ST_BUSY]      = w_busy;
        w_rdata[ST_EMPTY]     = w_empty;
        w_rdata[ST_FULL]      = w_full;
        w_rdata[ST_OVERRUN]   = r_overrun;
        w_rdata[ST_FRAME_ERR] = r_frame_err;
        w_rdata[ST_COUNT_LSB +: FIFO_AW + 1] = r_count;
      end
      default: w_rdata = '0;
    endcase
  end

  assign mmio_rdata     = w_rdata;
  assign rx_irq_o       = ~w_empty;
  assign fifo_count_o   = r_count;
  assign rx_byte_fire_o = w_push;

endmodule
